// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: LC-3b word/opcode types and memory-access FSM encodings
package mem_access_ctrl_pkg;
    typedef logic [15:0] lc3b_word;
    typedef logic [3:0] lc3b_opcode;
    localparam lc3b_opcode OP_LDB = 4'h2;
    localparam lc3b_opcode OP_STB = 4'h3;
    localparam lc3b_opcode OP_LDI = 4'ha;
    localparam lc3b_opcode OP_STI = 4'hb;
    typedef enum logic [1:0] {IDLE, FIRST, SECOND, DONE} mem_acc_state_t;
    typedef enum logic [2:0] {WORD_LD, WORD_ST, BYTE_LD, BYTE_ST, IND_LD, IND_ST} mem_acc_kind_t;
    // Opcode decides byte/indirect kinds; otherwise write wins over read.
    function automatic mem_acc_kind_t classify(lc3b_opcode op, logic wr);
        return op == OP_LDB ? BYTE_LD : op == OP_STB ? BYTE_ST : op == OP_LDI ? IND_LD :
               op == OP_STI ? IND_ST : wr ? WORD_ST : WORD_LD;
    endfunction
    function automatic logic is_load(mem_acc_kind_t k);
        return k inside {WORD_LD, BYTE_LD, IND_LD};
    endfunction
endpackage

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: data-memory handshake bus between the MEM sequencer and memory
interface mem_access_ctrl_if;
    import mem_access_ctrl_pkg::*;
    logic dmem_read;
    logic dmem_write;
    lc3b_word dmem_address;
    lc3b_word dmem_wdata;
    logic [1:0] dmem_byte_enable;
    logic dmem_resp;
    lc3b_word dmem_rdata;
    modport master(output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
                   input dmem_resp, dmem_rdata);
    modport slave(input dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_byte_enable,
                  output dmem_resp, dmem_rdata);
endinterface

// File: rtl/mem_access_ctrl_lane.sv
// mem_byte_lane: byte-lane steering for stores and zero-extended byte extraction for loads
module mem_byte_lane
    import mem_access_ctrl_pkg::*;
(
    input  mem_acc_kind_t kind,
    input  logic addr0,
    input  lc3b_word data,
    input  lc3b_word rdata,
    output lc3b_word wdata,
    output logic [1:0] byte_enable,
    output lc3b_word load_value
);
    logic byte_acc;
    assign byte_acc = kind inside {BYTE_LD, BYTE_ST};
    assign wdata = kind == BYTE_ST ? {data[7:0], data[7:0]} : data;
    assign byte_enable = !byte_acc ? 2'b11 : addr0 ? 2'b10 : 2'b01;
    assign load_value = kind != BYTE_LD ? rdata : {8'h00, addr0 ? rdata[15:8] : rdata[7:0]};
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-memory sequencer; expands LDI/STI into two accesses
// and stalls the pipeline while an access is outstanding.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic valid,
    input  lc3b_opcode opcode,
    input  logic read_memory,
    input  logic write_memory,
    input  lc3b_word address,
    input  lc3b_word store_data,
    mem_access_ctrl_if.master bus,
    output logic stall,
    output lc3b_word load_data,
    output logic load_data_valid
);
    mem_acc_state_t state;
    mem_acc_kind_t kind_q;
    mem_acc_kind_t new_kind;
    lc3b_word addr_q;
    lc3b_word data_q;
    lc3b_word pointer;
    lc3b_word lane_wdata;
    lc3b_word lane_load;
    logic [1:0] lane_be;
    logic req;
    logic first_wr;
    assign req = valid & (read_memory | write_memory);
    assign new_kind = classify(opcode, write_memory);
    assign first_wr = new_kind inside {WORD_ST, BYTE_ST};
    assign stall = state == IDLE ? req : state != DONE;
    assign bus.dmem_address = state == SECOND ? {pointer[15:1], 1'b0} :
                              state == FIRST ? {addr_q[15:1], 1'b0} : '0;
    // Steering uses the live inputs while accepting a request, latched values afterwards.
    mem_byte_lane lane (
        .kind(state == IDLE ? new_kind : kind_q),
        .addr0(state == IDLE ? address[0] : addr_q[0]),
        .data(store_data),
        .rdata(bus.dmem_rdata),
        .wdata(lane_wdata),
        .byte_enable(lane_be),
        .load_value(lane_load)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            kind_q <= WORD_LD;
            addr_q <= '0;
            data_q <= '0;
            pointer <= '0;
            bus.dmem_read <= 1'b0;
            bus.dmem_write <= 1'b0;
            bus.dmem_wdata <= '0;
            bus.dmem_byte_enable <= 2'b00;
            load_data <= '0;
            load_data_valid <= 1'b0;
        end else begin
            load_data_valid <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    state <= FIRST;
                    kind_q <= new_kind;
                    addr_q <= address;
                    data_q <= store_data;
                    bus.dmem_read <= !first_wr;
                    bus.dmem_write <= first_wr;
                    bus.dmem_wdata <= lane_wdata;
                    bus.dmem_byte_enable <= lane_be;
                end
                FIRST: if (bus.dmem_resp) begin
                    if (kind_q inside {IND_LD, IND_ST}) begin
                        state <= SECOND;
                        pointer <= bus.dmem_rdata;
                        bus.dmem_read <= kind_q == IND_LD;
                        bus.dmem_write <= kind_q == IND_ST;
                        bus.dmem_wdata <= data_q;
                        bus.dmem_byte_enable <= 2'b11;
                    end else begin
                        state <= DONE;
                        bus.dmem_read <= 1'b0;
                        bus.dmem_write <= 1'b0;
                        if (is_load(kind_q)) begin
                            load_data <= lane_load;
                            load_data_valid <= 1'b1;
                        end
                    end
                end
                SECOND: if (bus.dmem_resp) begin
                    state <= DONE;
                    bus.dmem_read <= 1'b0;
                    bus.dmem_write <= 1'b0;
                    if (is_load(kind_q)) begin
                        load_data <= lane_load;
                        load_data_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed checks of the MEM-stage access sequencer against hand-computed results
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;
    logic clk = 1'b0;
    logic reset_n;
    logic valid, read_memory, write_memory;
    logic [3:0] opcode;
    logic [15:0] address, store_data;
    logic stall, load_data_valid;
    logic [15:0] load_data;
    int checks = 0;
    int failures = 0;
    int stall_cycles, write_cycles, pulses, acc_n;
    logic overlap, unstable, timeout;
    logic [15:0] seen;
    logic [15:0] acc_addr [2];
    logic [15:0] acc_wdata [2];
    logic [1:0] acc_be [2];
    logic acc_rd [2];
    logic acc_wr [2];

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .clk(clk), .reset_n(reset_n), .valid(valid), .opcode(opcode),
        .read_memory(read_memory), .write_memory(write_memory), .address(address),
        .store_data(store_data), .bus(bus), .stall(stall), .load_data(load_data),
        .load_data_valid(load_data_valid)
    );

    always #5 clk = ~clk;

    // Presents one instruction, plays zero/multi-wait memory and records what the DUT did.
    task automatic do_access(input logic [3:0] op, input logic rd, input logic wr, input logic [15:0] a,
                             input logic [15:0] sd, input int w1, input logic [15:0] r1, input int w2,
                             input logic [15:0] r2);
        int wc;
        bit done;
        stall_cycles = 0; write_cycles = 0; pulses = 0; acc_n = 0; wc = 0; done = 0;
        overlap = 0; unstable = 0; timeout = 0; seen = 16'hxxxx;
        valid = 1; opcode = op; read_memory = rd; write_memory = wr; address = a; store_data = sd;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            if (bus.dmem_read && bus.dmem_write) overlap = 1;
            if (bus.dmem_write) write_cycles++;
            if (load_data_valid) begin pulses++; seen = load_data; end
            if (stall) stall_cycles++;
            else if (c > 0) begin done = 1; valid = 0; read_memory = 0; write_memory = 0; end
            if ((bus.dmem_read || bus.dmem_write) && acc_n < 2) begin
                if (wc == 0) begin
                    acc_addr[acc_n] = bus.dmem_address; acc_wdata[acc_n] = bus.dmem_wdata;
                    acc_be[acc_n] = bus.dmem_byte_enable; acc_rd[acc_n] = bus.dmem_read; acc_wr[acc_n] = bus.dmem_write;
                end else if (bus.dmem_address !== acc_addr[acc_n] || bus.dmem_wdata !== acc_wdata[acc_n] ||
                             bus.dmem_byte_enable !== acc_be[acc_n] || bus.dmem_read !== acc_rd[acc_n] ||
                             bus.dmem_write !== acc_wr[acc_n]) unstable = 1;
                if (wc == (acc_n == 0 ? w1 : w2)) begin
                    bus.dmem_resp = 1; bus.dmem_rdata = acc_n == 0 ? r1 : r2; acc_n++; wc = 0;
                end else wc++;
            end
            @(negedge clk);
            bus.dmem_resp = 0; bus.dmem_rdata = 16'hdead;
        end
        if (!done) begin timeout = 1; valid = 0; read_memory = 0; write_memory = 0; end
        #1;
        if (load_data_valid) pulses++;
        if (stall) stall_cycles++;
    endtask

    task automatic test_reset;
        reset_n = 0; valid = 0; read_memory = 0; write_memory = 0; opcode = 0; address = 0; store_data = 0;
        bus.dmem_resp = 0; bus.dmem_rdata = 16'hdead;
        @(negedge clk); #1;
        checks++;
        if ({bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_wdata, bus.dmem_byte_enable,
             stall, load_data, load_data_valid} !== 54'd0) begin
            failures++;
            $display("FAIL reset_outputs got rd=%b wr=%b addr=%h wd=%h be=%b stall=%b ld=%h ldv=%b want all 0",
                     bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_wdata, bus.dmem_byte_enable,
                     stall, load_data, load_data_valid);
        end
        valid = 1; read_memory = 1; #1;
        checks++;
        if (stall !== 1'b1) begin failures++; $display("FAIL reset_idle_stall got %b want 1", stall); end
        valid = 0; read_memory = 0;
        @(negedge clk); reset_n = 1;
        @(negedge clk);
    endtask

    task automatic test_word_load;
        do_access(4'h6, 1, 0, 16'h1235, 16'h0000, 0, 16'hbeef, 0, 16'h0000);
        checks++;
        if (timeout !== 0) begin failures++; $display("FAIL ldr_timeout got %b want 0", timeout); end
        checks++;
        if (acc_addr[0] !== 16'h1234 || acc_be[0] !== 2'b11 || acc_rd[0] !== 1 || acc_wr[0] !== 0) begin
            failures++;
            $display("FAIL ldr_access got addr=%h be=%b rd=%b wr=%b want addr=1234 be=11 rd=1 wr=0",
                     acc_addr[0], acc_be[0], acc_rd[0], acc_wr[0]);
        end
        checks++;
        if (stall_cycles !== 2) begin failures++; $display("FAIL ldr_stall got %0d want 2", stall_cycles); end
        checks++;
        if (pulses !== 1 || seen !== 16'hbeef) begin
            failures++; $display("FAIL ldr_result got pulses=%0d data=%h want 1 beef", pulses, seen);
        end
    endtask

    task automatic test_byte_store;
        do_access(OP_STB, 0, 1, 16'h2001, 16'h00a5, 3, 16'h0000, 0, 16'h0000);
        checks++;
        if (acc_addr[0] !== 16'h2000 || acc_wdata[0] !== 16'ha5a5 || acc_be[0] !== 2'b10 || acc_wr[0] !== 1) begin
            failures++;
            $display("FAIL stb_access got addr=%h wd=%h be=%b wr=%b want 2000 a5a5 10 1",
                     acc_addr[0], acc_wdata[0], acc_be[0], acc_wr[0]);
        end
        checks++;
        if (write_cycles !== 4 || stall_cycles !== 5) begin
            failures++; $display("FAIL stb_timing got write=%0d stall=%0d want 4 5", write_cycles, stall_cycles);
        end
        checks++;
        if (unstable !== 0 || pulses !== 0 || load_data !== 16'hbeef) begin
            failures++;
            $display("FAIL stb_hold got unstable=%b pulses=%0d ld=%h want 0 0 beef", unstable, pulses, load_data);
        end
    endtask

    task automatic test_byte_load;
        do_access(OP_LDB, 1, 0, 16'h3000, 16'h0000, 0, 16'h7f80, 0, 16'h0000);
        checks++;
        if (seen !== 16'h0080 || pulses !== 1 || stall_cycles !== 2) begin
            failures++;
            $display("FAIL ldb_low got data=%h pulses=%0d stall=%0d want 0080 1 2", seen, pulses, stall_cycles);
        end
        do_access(OP_LDB, 1, 0, 16'h3001, 16'h0000, 1, 16'h7f80, 0, 16'h0000);
        checks++;
        if (seen !== 16'h007f || pulses !== 1 || stall_cycles !== 3 || acc_addr[0] !== 16'h3000) begin
            failures++;
            $display("FAIL ldb_high got data=%h pulses=%0d stall=%0d addr=%h want 007f 1 3 3000",
                     seen, pulses, stall_cycles, acc_addr[0]);
        end
    endtask

    task automatic test_indirect_load;
        do_access(OP_LDI, 1, 0, 16'h4000, 16'h0000, 0, 16'h5003, 0, 16'h1111);
        checks++;
        if (acc_n !== 2 || acc_addr[0] !== 16'h4000 || acc_rd[0] !== 1 || acc_addr[1] !== 16'h5002 ||
            acc_rd[1] !== 1 || acc_be[1] !== 2'b11) begin
            failures++;
            $display("FAIL ldi_access got n=%0d a0=%h r0=%b a1=%h r1=%b be1=%b want 2 4000 1 5002 1 11",
                     acc_n, acc_addr[0], acc_rd[0], acc_addr[1], acc_rd[1], acc_be[1]);
        end
        checks++;
        if (seen !== 16'h1111 || pulses !== 1 || stall_cycles !== 3) begin
            failures++;
            $display("FAIL ldi_result got data=%h pulses=%0d stall=%0d want 1111 1 3", seen, pulses, stall_cycles);
        end
    endtask

    task automatic test_indirect_store;
        do_access(OP_STI, 0, 1, 16'h6000, 16'hcafe, 0, 16'h7000, 1, 16'h0000);
        checks++;
        if (acc_n !== 2 || acc_addr[0] !== 16'h6000 || acc_rd[0] !== 1 || acc_wr[0] !== 0 ||
            acc_addr[1] !== 16'h7000 || acc_wr[1] !== 1 || acc_rd[1] !== 0 || acc_wdata[1] !== 16'hcafe) begin
            failures++;
            $display("FAIL sti_access got n=%0d a0=%h rd0=%b a1=%h wr1=%b wd1=%h want 2 6000 1 7000 1 cafe",
                     acc_n, acc_addr[0], acc_rd[0], acc_addr[1], acc_wr[1], acc_wdata[1]);
        end
        checks++;
        if (overlap !== 0 || pulses !== 0 || stall_cycles !== 4 || load_data !== 16'h1111) begin
            failures++;
            $display("FAIL sti_misc got overlap=%b pulses=%0d stall=%0d ld=%h want 0 0 4 1111",
                     overlap, pulses, stall_cycles, load_data);
        end
    endtask

    task automatic test_write_wins;
        do_access(4'h7, 1, 1, 16'h8003, 16'h1234, 0, 16'h0000, 0, 16'h0000);
        checks++;
        if (acc_wr[0] !== 1 || acc_rd[0] !== 0 || acc_addr[0] !== 16'h8002 || acc_wdata[0] !== 16'h1234 ||
            acc_be[0] !== 2'b11 || pulses !== 0) begin
            failures++;
            $display("FAIL str_both_flags got wr=%b rd=%b addr=%h wd=%h be=%b pulses=%0d want 1 0 8002 1234 11 0",
                     acc_wr[0], acc_rd[0], acc_addr[0], acc_wdata[0], acc_be[0], pulses);
        end
    endtask

    task automatic test_back_to_back;
        do_access(4'hf, 1, 0, 16'h0021, 16'h0000, 0, 16'h0a0b, 0, 16'h0000);
        checks++;
        if (seen !== 16'h0a0b || stall_cycles !== 2 || pulses !== 1) begin
            failures++;
            $display("FAIL b2b_first got data=%h stall=%0d pulses=%0d want 0a0b 2 1", seen, stall_cycles, pulses);
        end
        do_access(OP_LDB, 1, 0, 16'h0031, 16'h0000, 0, 16'h9c00, 0, 16'h0000);
        checks++;
        if (seen !== 16'h009c || stall_cycles !== 2 || pulses !== 1) begin
            failures++;
            $display("FAIL b2b_second got data=%h stall=%0d pulses=%0d want 009c 2 1", seen, stall_cycles, pulses);
        end
    endtask

    task automatic test_reset_mid_access;
        valid = 1; opcode = OP_LDI; read_memory = 1; write_memory = 0; address = 16'h4000;
        @(negedge clk);
        #1 bus.dmem_resp = 1; bus.dmem_rdata = 16'h5003;
        @(negedge clk);
        bus.dmem_resp = 0; bus.dmem_rdata = 16'hdead;
        #1;
        checks++;
        if (bus.dmem_read !== 1 || bus.dmem_address !== 16'h5002) begin
            failures++;
            $display("FAIL rst_pre_second got rd=%b addr=%h want 1 5002", bus.dmem_read, bus.dmem_address);
        end
        #2 reset_n = 0; valid = 0; read_memory = 0;
        #1;
        checks++;
        if ({bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_wdata, bus.dmem_byte_enable,
             stall, load_data, load_data_valid} !== 54'd0) begin
            failures++;
            $display("FAIL rst_mid_clear got rd=%b wr=%b addr=%h wd=%h be=%b stall=%b ld=%h ldv=%b want all 0",
                     bus.dmem_read, bus.dmem_write, bus.dmem_address, bus.dmem_wdata, bus.dmem_byte_enable,
                     stall, load_data, load_data_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (load_data_valid !== 0 || bus.dmem_read !== 0) begin
            failures++; $display("FAIL rst_mid_hold got ldv=%b rd=%b want 0 0", load_data_valid, bus.dmem_read);
        end
        reset_n = 1;
        @(negedge clk);
        do_access(4'h6, 1, 0, 16'h0010, 16'h0000, 1, 16'h2222, 0, 16'h0000);
        checks++;
        if (timeout !== 0 || seen !== 16'h2222 || pulses !== 1 || stall_cycles !== 3 || acc_addr[0] !== 16'h0010) begin
            failures++;
            $display("FAIL rst_then_ldr got to=%b data=%h pulses=%0d stall=%0d addr=%h want 0 2222 1 3 0010",
                     timeout, seen, pulses, stall_cycles, acc_addr[0]);
        end
    endtask

    initial begin
        test_reset;
        test_word_load;
        test_byte_store;
        test_byte_load;
        test_indirect_load;
        test_indirect_store;
        test_write_wins;
        test_back_to_back;
        test_reset_mid_access;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
